// File: rtl/switch_pulse_gen.sv
// switch_pulse_gen: debounced two-button on/off pulse generator (optional SWITCH_PULSE_GEN_OFF_PRIORITY_EN off-priority interlock)
module switch_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN_ON_RAW,
    input  logic BTN_OFF_RAW,
    output logic SW_ON,
    output logic SW_OFF,
    output logic ON_LVL,
    output logic OFF_LVL
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [1:0] raw, lvl, lvl_nxt, rise;
    logic on_ok;
    assign raw = {BTN_OFF_RAW, BTN_ON_RAW};
    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic s1, s2, l, ld, ln;
        logic [CW-1:0] cnt, cnt_nxt;
        // count consecutive disagreeing cycles; accept the new level on the last one
        always_comb begin
            ln      = l;
            cnt_nxt = '0;
            if (s2 != l) begin
                if (cnt == CNT_LAST) ln = s2;
                else cnt_nxt = cnt + 1'b1;
            end
        end
        // synchronizer, debounce state and delayed level for edge detection
        always_ff @(posedge CLK) begin
            if (RST) begin
                s1  <= 1'b0;
                s2  <= 1'b0;
                l   <= 1'b0;
                ld  <= 1'b0;
                cnt <= '0;
            end else begin
                s1  <= raw[c];
                s2  <= s1;
                l   <= ln;
                ld  <= l;
                cnt <= cnt_nxt;
            end
        end
        assign lvl[c]     = l;
        assign lvl_nxt[c] = ln;
        assign rise[c]    = l & ~ld;
    end
`ifdef SWITCH_PULSE_GEN_OFF_PRIORITY_EN
    assign on_ok = ~lvl_nxt[1];
`else
    assign on_ok = 1'b1;
`endif
    // one-cycle pulses the cycle after a debounced level rises
    always_ff @(posedge CLK) begin
        if (RST) begin
            SW_ON  <= 1'b0;
            SW_OFF <= 1'b0;
        end else begin
            SW_ON  <= rise[0] & on_ok;
            SW_OFF <= rise[1];
        end
    end
    assign ON_LVL  = lvl[0];
    assign OFF_LVL = lvl[1];
endmodule

// File: doc/switch_pulse_gen.md
SWITCH_PULSE_GEN -- requirements
Module: switch_pulse_gen

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning consecutive synchronized cycles an input change must hold to be accepted; legal range 2..65535.
REQ-002 SHALL have port CLK  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port BTN_ON_RAW  input  1  raw "on" button, asynchronous to CLK, active-high, may bounce.
REQ-005 SHALL have port BTN_OFF_RAW  input  1  raw "off" button, asynchronous to CLK, active-high, may bounce.
REQ-006 SHALL have port SW_ON  output  1  one-cycle registered pulse on accepted "on" press.
REQ-007 SHALL have port SW_OFF  output  1  one-cycle registered pulse on accepted "off" press.
REQ-008 SHALL have port ON_LVL  output  1  debounced level of the "on" button.
REQ-009 SHALL have port OFF_LVL  output  1  debounced level of the "off" button.

Function
REQ-010 SHALL pass each raw input through its own 2-flop synchronizer before any other use.
REQ-011 SHALL keep, per channel, a debounced level register (drives ON_LVL/OFF_LVL) and a counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-012 SHALL clear the channel counter in any cycle where the synchronized input equals the debounced level.
REQ-013 SHALL increment the channel counter in any cycle where the synchronized input differs from the debounced level.
REQ-014 SHALL, when the counter equals DEBOUNCE_CYCLES-1 and the input still differs, load the input into the debounced level and clear the counter (change accepted after exactly DEBOUNCE_CYCLES differing cycles).
REQ-015 SHALL treat any agreeing cycle mid-count (bounce shorter than DEBOUNCE_CYCLES) as restarting the count from 0; the counter never wraps.
REQ-016 SHALL assert SW_ON for exactly one cycle, in the cycle after ON_LVL goes 0->1; likewise SW_OFF after OFF_LVL goes 0->1.
REQ-017 SHALL produce no pulse on release (level 1->0) and no repeat pulse while a button stays held.
REQ-018 SHALL give latency of DEBOUNCE_CYCLES+3 rising edges from the first edge sampling a stable raw high to the edge that raises the pulse.
REQ-019 SHALL handle both channels independently; simultaneous accepted presses produce SW_ON and SW_OFF in the same cycle (unless REQ-025 applies).
REQ-020 SHALL, for a button held through reset, treat it as a new press after reset deassertion and emit one pulse after the normal latency.

Reset
REQ-021 SHALL, while RST=1 at a rising edge, clear synchronizer flops, counters, debounced levels and pulse registers to 0.
REQ-022 SHALL drive SW_ON=0, SW_OFF=0, ON_LVL=0, OFF_LVL=0 in the cycle after any reset edge.
REQ-023 SHALL abort any in-progress count on reset mid-operation; no pulse originates from pre-reset activity except per REQ-020.

Configuration
REQ-024 SHALL compile the off-priority interlock only when macro SWITCH_PULSE_GEN_OFF_PRIORITY_EN is defined.
REQ-025 SHALL, with the macro defined, suppress SW_ON in any cycle where OFF_LVL=1 (including a same-cycle accepted off press); SW_OFF unaffected; a suppressed SW_ON is dropped, not deferred.
REQ-026 SHALL, without the macro, generate SW_ON independently of the off channel per REQ-019.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 SHALL cover clean press: BTN_ON_RAW 0->1 held 20 cycles -> SW_ON high exactly one cycle, raised at edge 7 after first sampling edge; ON_LVL stays 1; SW_OFF stays 0.
REQ-028 SHALL cover bounce: BTN_ON_RAW high 3 cycles, low 1, high 3, low -> no SW_ON, ON_LVL stays 0.
REQ-029 SHALL cover release and hold: hold BTN_OFF_RAW 30 cycles then release -> one SW_OFF pulse total, OFF_LVL returns 0 four cycles after synchronized release, no pulse on release.
REQ-030 SHALL cover simultaneous press: both raw inputs rise same cycle -> macro undefined: SW_ON and SW_OFF high in same cycle; macro defined: SW_OFF only.
REQ-031 SHALL cover reset mid-count: BTN_ON_RAW high, RST=1 for one edge at count 2, raw still high -> all outputs 0 after reset, then one SW_ON at edge 7 counted from the first post-reset edge.
